// File: rtl/c157x_head_stepper.sv
// Stepper-phase decoder for the 1541-style drive head: produces the half-track number
// for the track loader and paces save_track toggles so buffered writes reach SD.
module c157x_head_stepper #(
    parameter int MAX_HTRACK  = 83,
    parameter int INIT_HTRACK = 36,
    parameter int SAVE_DELAY  = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       wr_strobe,
    input  logic       busy,
    output logic [7:0] track,
    output logic       save_track,
    output logic       dirty,
    output logic       tr00_n
);

    localparam logic [7:0]  MAX_T  = 8'(MAX_HTRACK);
    localparam logic [7:0]  INIT_T = 8'(INIT_HTRACK);
    localparam logic [19:0] DELAY  = 20'(SAVE_DELAY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [7:0]  track_q, track_d;
    logic [1:0]  stp_prev_q, stp_prev_d;
    logic        mtr_prev_q;
    logic        dirty_q, dirty_d;
    logic        pend_q, pend_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        save_track_q = 1'b0;
    logic        save_track_d;

    logic [1:0]  stp_fwd, stp_back;
    logic        moved, flush_fire, pend_set, toggle;

    assign stp_fwd  = stp_prev_q + 2'd1;
    assign stp_back = stp_prev_q - 2'd1;

    always_comb begin
        stp_prev_d = stp_prev_q;
        track_d    = track_q;
        moved      = 1'b0;
        if (ce) begin
            stp_prev_d = stp;
            if (mtr) begin
                if (stp == stp_fwd) begin
                    if (track_q != MAX_T) begin
                        track_d = track_q + 8'd1;
                        moved   = 1'b1;
                    end
                end else if (stp == stp_back) begin
                    if (track_q != 8'd0) begin
                        track_d = track_q - 8'd1;
                        moved   = 1'b1;
                    end
                end
            end
        end
    end

    // Motor-off flush timer: idle whenever cnt_q is zero.
    always_comb begin
        cnt_d      = cnt_q;
        flush_fire = 1'b0;
        if (mtr) begin
            cnt_d = 20'd0;
        end else if (mtr_prev_q && dirty_q) begin
            cnt_d = DELAY;
        end else if (cnt_q != 20'd0) begin
            if (wr_strobe) begin
                cnt_d = DELAY;
            end else if (ce) begin
                cnt_d = cnt_q - 20'd1;
                if (cnt_q == 20'd1) flush_fire = 1'b1;
            end
        end
    end

    always_comb begin
        pend_set = (moved && dirty_q) || flush_fire;
        dirty_d  = dirty_q;
        if (pend_set)  dirty_d = 1'b0;
        if (wr_strobe) dirty_d = 1'b1;
    end

    // WAIT holds off the next toggle until the loader has seen this one.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        toggle  = 1'b0;
        case (state_q)
            S_IDLE: if (pend_q) state_d = S_ARM;
            S_ARM: begin
                if (!busy) begin
                    toggle  = 1'b1;
                    state_d = S_WAIT;
                    wait_d  = 4'd0;
                end
            end
            S_WAIT: begin
                if (busy || wait_q == 4'd15) state_d = S_IDLE;
                else                         wait_d  = wait_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
        pend_d = pend_q;
        if (toggle)   pend_d = 1'b0;
        if (pend_set) pend_d = 1'b1;
        save_track_d = save_track_q ^ toggle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            track_q    <= INIT_T;
            stp_prev_q <= stp;
            mtr_prev_q <= mtr;
            dirty_q    <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= 20'd0;
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
        end else begin
            track_q    <= track_d;
            stp_prev_q <= stp_prev_d;
            mtr_prev_q <= mtr;
            dirty_q    <= dirty_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            wait_q     <= wait_d;
        end
    end

    // save_track survives reset so the loader never sees a spurious edge.
    always_ff @(posedge clk) begin
        if (!reset) save_track_q <= save_track_d;
    end

    assign track      = track_q;
    assign save_track = save_track_q;
    assign dirty      = dirty_q;
    assign tr00_n     = (track_q != 8'd0);

endmodule

// File: tb/tb_c157x_head_stepper.sv
// Directed bench for c157x_head_stepper with a short motor-off delay (100 ce ticks).
module tb_c157x_head_stepper;

    logic       clk = 1'b0;
    logic       reset, ce, mtr, wr_strobe, busy;
    logic [1:0] stp;
    logic [7:0] track;
    logic       save_track, dirty, tr00_n;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] ph;
    int         exp_track;
    logic       exp_save;

    c157x_head_stepper #(
        .MAX_HTRACK (83),
        .INIT_HTRACK(36),
        .SAVE_DELAY (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .stp       (stp),
        .mtr       (mtr),
        .wr_strobe (wr_strobe),
        .busy      (busy),
        .track     (track),
        .save_track(save_track),
        .dirty     (dirty),
        .tr00_n    (tr00_n)
    );

    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_ce(input logic [1:0] s);
        @(negedge clk);
        stp = s;
        ce  = 1'b1;
        @(negedge clk);
        ce  = 1'b0;
    endtask

    task automatic step_in();
        ph = ph + 2'd1;
        step_ce(ph);
        if (mtr && exp_track < 83) exp_track++;
    endtask

    task automatic step_out();
        ph = ph - 2'd1;
        step_ce(ph);
        if (mtr && exp_track > 0) exp_track--;
    endtask

    task automatic wr_pulse();
        @(negedge clk);
        wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
    endtask

    task automatic ce_pulse();
        @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        clks(2);
    endtask

    task automatic test_reset();
        n_vec++; if (track !== 8'd36) begin n_err++; $display("FAIL reset_track got %0d want 36", track); end
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL reset_dirty got %b want 0", dirty); end
        n_vec++; if (tr00_n !== 1'b1) begin n_err++; $display("FAIL reset_tr00_n got %b want 1", tr00_n); end
        n_vec++; if (save_track !== 1'b0) begin n_err++; $display("FAIL reset_save got %b want 0", save_track); end
        $display("test_reset: track=%0d dirty=%b tr00_n=%b save=%b", track, dirty, tr00_n, save_track);
    endtask

    task automatic test_step_in();
        @(negedge clk);
        mtr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_in();
            n_vec++; if (track !== 8'(exp_track)) begin n_err++; $display("FAIL step_in_%0d got %0d want %0d", i, track, exp_track); end
        end
        n_vec++; if (track !== 8'd40) begin n_err++; $display("FAIL step_in_end got %0d want 40", track); end
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL step_in_save got %b want %b", save_track, exp_save); end
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL step_in_dirty got %b want 0", dirty); end
        ph = ph + 2'd2;
        step_ce(ph);
        n_vec++; if (track !== 8'd40) begin n_err++; $display("FAIL step_plus2 got %0d want 40", track); end
        step_out();
        n_vec++; if (track !== 8'd39) begin n_err++; $display("FAIL step_out got %0d want 39", track); end
        $display("test_step_in: track=%0d save=%b", track, save_track);
    endtask

    task automatic test_saturate_low();
        while (exp_track > 1) step_out();
        n_vec++; if (track !== 8'd1) begin n_err++; $display("FAIL low_at1 got %0d want 1", track); end
        step_out();
        n_vec++; if (track !== 8'd0) begin n_err++; $display("FAIL low_at0 got %0d want 0", track); end
        n_vec++; if (tr00_n !== 1'b0) begin n_err++; $display("FAIL low_tr00_n got %b want 0", tr00_n); end
        wr_pulse();
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL low_wr_dirty got %b want 1", dirty); end
        step_out();
        clks(6);
        n_vec++; if (track !== 8'd0) begin n_err++; $display("FAIL low_sat got %0d want 0", track); end
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL low_sat_dirty got %b want 1", dirty); end
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL low_sat_save got %b want %b", save_track, exp_save); end
        $display("test_saturate_low: track=%0d dirty=%b save=%b", track, dirty, save_track);
    endtask

    task automatic test_move_flush();
        busy = 1'b0;
        step_in();
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL flush_dirty got %b want 0", dirty); end
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL flush_t0 got %b want %b", save_track, exp_save); end
        clks(1);
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL flush_t1 got %b want %b", save_track, exp_save); end
        clks(1);
        exp_save = ~exp_save;
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL flush_t2 got %b want %b", save_track, exp_save); end
        clks(20);
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL flush_once got %b want %b", save_track, exp_save); end
        n_vec++; if (track !== 8'd1) begin n_err++; $display("FAIL flush_track got %0d want 1", track); end
        $display("test_move_flush: track=%0d save=%b", track, save_track);
    endtask

    task automatic test_saturate_high();
        while (exp_track < 83) step_in();
        n_vec++; if (track !== 8'd83) begin n_err++; $display("FAIL high_at83 got %0d want 83", track); end
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL high_clean_save got %b want %b", save_track, exp_save); end
        wr_pulse();
        step_in();
        clks(6);
        n_vec++; if (track !== 8'd83) begin n_err++; $display("FAIL high_sat got %0d want 83", track); end
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL high_sat_dirty got %b want 1", dirty); end
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL high_sat_save got %b want %b", save_track, exp_save); end
        $display("test_saturate_high: track=%0d dirty=%b save=%b", track, dirty, save_track);
    endtask

    task automatic test_busy_merge();
        int   toggles;
        logic prev;
        @(negedge clk);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wr_pulse();
            step_out();
        end
        clks(20);
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL busy_hold got %b want %b", save_track, exp_save); end
        n_vec++; if (track !== 8'd80) begin n_err++; $display("FAIL busy_track got %0d want 80", track); end
        busy    = 1'b0;
        toggles = 0;
        prev    = save_track;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (save_track !== prev) toggles++;
            prev = save_track;
        end
        exp_save = ~exp_save;
        n_vec++; if (toggles != 1) begin n_err++; $display("FAIL busy_toggles got %0d want 1", toggles); end
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL busy_save got %b want %b", save_track, exp_save); end
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL busy_dirty got %b want 0", dirty); end
        $display("test_busy_merge: toggles=%0d save=%b", toggles, save_track);
    endtask

    task automatic test_motor_off();
        wr_pulse();
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL moff_dirty_set got %b want 1", dirty); end
        @(negedge clk);
        mtr = 1'b0;
        repeat (98) ce_pulse();
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL moff_early got %b want %b", save_track, exp_save); end
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL moff_early_dirty got %b want 1", dirty); end
        repeat (3) ce_pulse();
        exp_save = ~exp_save;
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL moff_fire got %b want %b", save_track, exp_save); end
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL moff_fire_dirty got %b want 0", dirty); end
        $display("test_motor_off: save=%b dirty=%b", save_track, dirty);
    endtask

    task automatic test_motor_cancel();
        wr_pulse();
        @(negedge clk);
        mtr = 1'b1;
        clks(2);
        mtr = 1'b0;
        repeat (50) ce_pulse();
        @(negedge clk);
        mtr = 1'b1;
        repeat (60) ce_pulse();
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL cancel_save got %b want %b", save_track, exp_save); end
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL cancel_dirty got %b want 1", dirty); end
        $display("test_motor_cancel: save=%b dirty=%b", save_track, dirty);
    endtask

    task automatic test_reset_wait();
        step_in();
        clks(2);
        exp_save = ~exp_save;
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL rw_first got %b want %b", save_track, exp_save); end
        clks(30);
        wr_pulse();
        step_in();
        clks(2);
        exp_save = ~exp_save;
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL rw_second got %b want %b", save_track, exp_save); end
        wr_pulse();
        @(negedge clk);
        reset = 1'b1;
        clks(2);
        reset = 1'b0;
        exp_track = 36;
        n_vec++; if (save_track !== 1'b1) begin n_err++; $display("FAIL rw_save_held got %b want 1", save_track); end
        n_vec++; if (track !== 8'd36) begin n_err++; $display("FAIL rw_track got %0d want 36", track); end
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL rw_dirty got %b want 0", dirty); end
        wr_pulse();
        step_in();
        n_vec++; if (track !== 8'd37) begin n_err++; $display("FAIL rw_move got %0d want 37", track); end
        clks(2);
        exp_save = ~exp_save;
        n_vec++; if (save_track !== exp_save) begin n_err++; $display("FAIL rw_idle got %b want %b", save_track, exp_save); end
        $display("test_reset_wait: track=%0d save=%b dirty=%b", track, save_track, dirty);
    endtask

    initial begin
        reset     = 1'b1;
        ce        = 1'b0;
        mtr       = 1'b0;
        wr_strobe = 1'b0;
        busy      = 1'b0;
        ph        = 2'd0;
        stp       = 2'd0;
        exp_track = 36;
        exp_save  = 1'b0;
        clks(3);
        reset = 1'b0;
        clks(1);
        test_reset();
        test_step_in();
        test_saturate_low();
        test_move_flush();
        test_saturate_high();
        test_busy_merge();
        test_motor_off();
        test_motor_cancel();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
